// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (oversample rate, TX state encoding) for the TX and future RX blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Baud ticks per serial bit.
    localparam int OVERSAMPLE = 16;

    // PARITY is always encoded so TX and RX agree on state values, even when parity is not built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Sizes counters that have a minimum width.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_drain_baud_gen.sv
// Purpose: runtime-programmable baud tick generator; one tick every dvsr+1 clk cycles.
// Latency: first tick dvsr+1 cycles after clr; a new dvsr is adopted at the next wrap or clr.
// Backpressure: none; free-running, resynchronised by clr.
module baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);

    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [DVSR_W-1:0] lim_q, lim_d;

    // The limit is held for a whole period so a divisor change never shortens or stretches a period.
    always_comb begin
        tick  = (cnt_q == lim_q);
        cnt_d = cnt_q + DVSR_W'(1);
        lim_d = lim_q;
        if (clr || tick) begin
            cnt_d = '0;
            lim_d = dvsr;
        end
    end

    // Counter and latched limit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// Purpose: UART transmitter draining a show-ahead FIFO; frames are start, data LSB first, [parity], stop.
// Latency: pop in cycle T0, start bit on tx from T0+1; idle-to-idle gap between frames is one cycle.
// Backpressure: pops only from IDLE when the FIFO is non-empty; never pops while a frame is in flight.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_W     = 11,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DVSR_W-1:0]     dvsr,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    // One tick counter serves all states; it must hold both 0..15 and 0..SB_TICK-1.
    localparam int S_W = max_int(4, $clog2(SB_TICK));
    localparam int N_W = max_int(1, $clog2(DATA_WIDTH));

    localparam logic [S_W-1:0] OS_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST  = N_W'(DATA_WIDTH - 1);

    // Reject parameter values the frame logic cannot honour.
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_tx_drain: PARITY_ODD must be 0 or 1");
    end
    if (SB_TICK < 1) begin : g_bad_sb_tick
        $error("uart_tx_drain: SB_TICK must be at least 1");
    end

    tx_state_t             state_q, state_d;
    logic [S_W-1:0]        s_q, s_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  pop;
    logic                  frame_end;
    logic                  tick;
`ifdef UART_TX_PARITY_EN
    // Parity is computed from the whole word at pop time, before shifting destroys it.
    logic                  par_q, par_d;
`endif

    // Baud counter is cleared on every pop so each frame starts on a full tick period.
    baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (pop),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    // Frame sequencer: pop in IDLE, then count OVERSAMPLE ticks per bit and SB_TICK ticks of stop.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        frame_end = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = r_data;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^r_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == SB_LAST) begin
                        s_d       = '0;
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so the registered tx lines up with the state.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and the registered line driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Strobes are masked during reset so an aborting reset never pops the FIFO or reports a frame.
    assign rd      = pop && !reset;
    assign tx_done = frame_end && !reset;
    assign tx_busy = !reset && ((state_q != IDLE) || pop);
    assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a show-ahead FIFO model and a per-cycle tx/busy log.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Parity checks are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LOG = 8192;
    localparam int ST  = 1 + 16 * (NB - 1);

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic        empty;
    logic [7:0]  r_data;
    logic        rd;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fifo[$];
    logic       txlog[LOG];
    logic       busylog[LOG];
    int         rd_cyc[16];
    int         rd_cnt    = 0;
    int         done_cnt  = 0;
    int         last_done = -1;
    int         bad_rd    = 0;
    int         cyc       = 0;

    always #5 clk = ~clk;

    uart_tx_drain #(
        .DATA_WIDTH (8),
        .SB_TICK    (16),
        .DVSR_W     (11),
        .PARITY_ODD (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dvsr    (dvsr),
        .empty   (empty),
        .r_data  (r_data),
        .rd      (rd),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    task automatic refresh();
        empty  = (fifo.size() == 0);
        r_data = empty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    // One clock cycle: log outputs at the falling edge, then let the FIFO model act on rd.
    task automatic step();
        logic rd_s;
        @(negedge clk);
        rd_s = rd;
        if (cyc < LOG) begin
            txlog[cyc]   = tx;
            busylog[cyc] = tx_busy;
        end
        if (rd) begin
            if (rd_cnt < 16) rd_cyc[rd_cnt] = cyc;
            rd_cnt++;
            if (empty) bad_rd++;
        end
        if (tx_done) begin
            done_cnt++;
            last_done = cyc;
        end
        @(posedge clk);
        #1;
        if (rd_s && fifo.size() > 0) void'(fifo.pop_front());
        refresh();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until a new pop is seen, bounded; t0 is the pop cycle or -1 on timeout.
    task automatic wait_pop(output int t0);
        int n0;
        int k;
        n0 = rd_cnt;
        k  = 0;
        t0 = -1;
        while (rd_cnt == n0 && k < 64) begin
            step();
            k++;
        end
        if (rd_cnt != n0 && rd_cnt <= 16) t0 = rd_cyc[rd_cnt - 1];
        checks++;
        assert (t0 >= 0) else begin
            failures++;
            $error("FAIL pop_timeout: observed=%0d expected=pop within 64 cycles", t0);
        end
    endtask

    function automatic logic txl(input int i);
        return (i >= 0 && i < LOG) ? txlog[i] : 1'bx;
    endfunction

    function automatic logic bsl(input int i);
        return (i >= 0 && i < LOG) ? busylog[i] : 1'bx;
    endfunction

    // Samples each data bit at its centre; bit i occupies cycles t0+1+bitlen*(1+i) onwards.
    function automatic logic [7:0] decode(input int t0, input int bitlen);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = txl(t0 + 1 + bitlen * (1 + i) + bitlen / 2);
        return b;
    endfunction

    initial begin
        int t0;
        int t1;
        int n0;
        int d0;

        reset  = 1'b1;
        dvsr   = 11'd0;
        empty  = 1'b1;
        r_data = 8'h00;
        @(posedge clk);
        #1;

        // Reset held three cycles with an empty FIFO.
        run(3);
        `CHK("reset_tx", tx, 1'b1)
        `CHK("reset_rd", rd, 1'b0)
        `CHK("reset_busy", tx_busy, 1'b0)
        `CHK("reset_done", tx_done, 1'b0)
        reset = 1'b0;
        run(4);
        `CHK("idle_no_pop", rd_cnt, 0)
        `CHK("idle_busy", tx_busy, 1'b0)
        `CHK("idle_tx", tx, 1'b1)

        // Single frame, byte A5, dvsr=0.
        push(8'hA5);
        wait_pop(t0);
        run(NB * 16 + 4);
        `CHK("a5_rd_count", rd_cnt, 1)
        `CHK("a5_tx_pop_cycle", txl(t0), 1'b1)
        `CHK("a5_start_first", txl(t0 + 1), 1'b0)
        `CHK("a5_start_last", txl(t0 + 16), 1'b0)
        `CHK("a5_bit0_first", txl(t0 + 17), 1'b1)
        `CHK("a5_byte", decode(t0, 16), 8'hA5)
        `CHK("a5_stop_first", txl(t0 + ST), 1'b1)
        `CHK("a5_stop_last", txl(t0 + NB * 16), 1'b1)
        `CHK("a5_done_cycle", last_done - t0, NB * 16)
        `CHK("a5_done_count", done_cnt, 1)
        `CHK("a5_busy_pop", bsl(t0), 1'b1)
        `CHK("a5_busy_end", bsl(t0 + NB * 16), 1'b1)
        `CHK("a5_busy_after", bsl(t0 + NB * 16 + 1), 1'b0)

        // Back-to-back frames 00 then FF.
        n0 = rd_cnt;
        push(8'h00);
        push(8'hFF);
        wait_pop(t0);
        run(2 * (NB * 16 + 1) + 4);
        `CHK("b2b_rd_count", rd_cnt - n0, 2)
        t1 = (n0 + 1 < 16) ? rd_cyc[n0 + 1] : -1;
        `CHK("b2b_spacing", t1 - t0, NB * 16 + 1)
        `CHK("b2b_byte0", decode(t0, 16), 8'h00)
        `CHK("b2b_byte1", decode(t1, 16), 8'hFF)
        `CHK("b2b_gap_idle", txl(t0 + NB * 16 + 1), 1'b1)
        `CHK("b2b_second_start", txl(t1 + 1), 1'b0)

        // Slow baud, dvsr=9: every bit is 160 cycles.
        dvsr = 11'd9;
        n0   = rd_cnt;
        d0   = done_cnt;
        push(8'h3C);
        wait_pop(t0);
        run(NB * 160 + 4);
        `CHK("div9_rd_count", rd_cnt - n0, 1)
        `CHK("div9_start_end", txl(t0 + 160), 1'b0)
        `CHK("div9_byte", decode(t0, 160), 8'h3C)
        `CHK("div9_done_cycle", last_done - t0, NB * 160)
        `CHK("div9_done_count", done_cnt - d0, 1)

        // Reset in the middle of the data bits aborts the frame.
        dvsr = 11'd0;
        push(8'h55);
        wait_pop(t0);
        run(40);
        d0    = done_cnt;
        reset = 1'b1;
        step();
        `CHK("abort_tx", tx, 1'b1)
        `CHK("abort_busy", tx_busy, 1'b0)
        `CHK("abort_done", tx_done, 1'b0)
        n0 = rd_cnt;
        push(8'h96);
        step();
        `CHK("abort_no_pop_in_reset", rd_cnt - n0, 0)
        reset = 1'b0;
        wait_pop(t0);
        run(NB * 16 + 4);
        `CHK("abort_fresh_byte", decode(t0, 16), 8'h96)
        `CHK("abort_fresh_done", last_done - t0, NB * 16)
        `CHK("abort_done_count", done_cnt - d0, 1)

`ifdef UART_TX_PARITY_EN
        // Even parity on 07 (three ones) gives a parity bit of 1.
        push(8'h07);
        wait_pop(t0);
        run(NB * 16 + 4);
        `CHK("par_byte", decode(t0, 16), 8'h07)
        `CHK("par_bit", txl(t0 + 1 + 16 * 9 + 8), 1'b1)
        `CHK("par_stop_first", txl(t0 + 161), 1'b1)
        `CHK("par_done_cycle", last_done - t0, 176)
`endif

        `CHK("no_rd_while_empty", bad_rd, 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

`undef CHK

endmodule
